parking_lot_controller: RTL

- Sequencing controller for the 8-space parking lot.
- Serialises entry and exit requests through a single gate and owns the occupancy register.
- On entry, allocates the lowest-numbered free space. On exit, clears the space using the existing exit_parking_lot 3-to-8 active-low decoder as the clear mask.
- Drives the gate-open timing and publishes occupancy and status to the display/top level.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/exit_parking_lot.sv | 23 ++
 rtl/free_space_finder.sv | 29 ++
 rtl/parking_lot_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared constants and the controller state encoding for the 8-space parking
// lot. Imported by every file of the parking lot controller.
// -----------------------------------------------------------------------------
package parking_pkg;

    localparam int unsigned NUM_SPACES = 8;
    localparam int unsigned SPACE_W    = 3;
    localparam int unsigned COUNT_W    = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ENTRY_GRANT = 3'd1,
        EXIT_GRANT  = 3'd2,
        GATE_HOLD   = 3'd3,
        RELEASE     = 3'd4
    } state_t;

endpackage : parking_pkg

// File: rtl/exit_parking_lot.sv
// -----------------------------------------------------------------------------
// exit_parking_lot
// 3-to-8 active-low decoder. The output has a single 0 at the position
// selected by the input, so it can be ANDed into the occupancy register to
// clear one space.
//
// Ports:
//   exit_number_i  in  3  space index to decode
//   clear_n_o      out 8  active-low one-hot mask (bit exit_number_i is 0)
// -----------------------------------------------------------------------------
module exit_parking_lot
    import parking_pkg::*;
(
    input  logic [SPACE_W-1:0]    exit_number_i,
    output logic [NUM_SPACES-1:0] clear_n_o
);

    always_comb begin
        clear_n_o = '1;
        clear_n_o[exit_number_i] = 1'b0;
    end

endmodule : exit_parking_lot

// File: rtl/free_space_finder.sv
// -----------------------------------------------------------------------------
// free_space_finder
// Combinational priority encoder returning the lowest-numbered free space.
//
// Ports:
//   occupancy_i   in  8  bit i=1 means space i is occupied
//   idx_o         out 3  index of the lowest 0 bit (0 when none free)
//   none_free_o   out 1  all spaces occupied
// -----------------------------------------------------------------------------
module free_space_finder
    import parking_pkg::*;
(
    input  logic [NUM_SPACES-1:0] occupancy_i,
    output logic [SPACE_W-1:0]    idx_o,
    output logic                  none_free_o
);

    always_comb begin
        idx_o       = '0;
        none_free_o = &occupancy_i;
        // Scan from the top down so the last hit is the lowest free index.
        for (int i = NUM_SPACES - 1; i >= 0; i--) begin
            if (!occupancy_i[i]) begin
                idx_o = SPACE_W'(i);
            end
        end
    end

endmodule : free_space_finder

// File: rtl/parking_lot_controller.sv
// -----------------------------------------------------------------------------
// parking_lot_controller
// Serialises entry and exit requests through the single gate, owns the
// occupancy register, allocates the lowest free space on entry and clears the
// vacated space on exit, and times the gate opening.
//
// Parameters:
//   GATE_CYCLES  cycles gate_open stays high after a successful grant (1..255)
//
// Ports:
//   clk           in  1  system clock, rising edge
//   reset_n       in  1  asynchronous active-low reset
//   entry_req     in  1  level entry request, held until entry_ack
//   exit_req      in  1  level exit request, held until exit_ack
//   exit_number   in  3  space being vacated, stable while exit_req=1
//   entry_ack     out 1  one-cycle entry grant
//   entry_number  out 3  allocated space while entry_ack=1, else 0
//   exit_ack      out 1  one-cycle exit grant (also on error)
//   exit_err      out 1  with exit_ack when the space was already free
//   occupancy     out 8  bit i=1 means space i occupied
//   free_count    out 4  number of free spaces
//   full          out 1  all spaces occupied
//   empty         out 1  no space occupied
//   gate_open     out 1  gate actuator
//   busy          out 1  controller not in IDLE
// -----------------------------------------------------------------------------
module parking_lot_controller
    import parking_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  entry_req,
    input  logic                  exit_req,
    input  logic [SPACE_W-1:0]    exit_number,
    output logic                  entry_ack,
    output logic [SPACE_W-1:0]    entry_number,
    output logic                  exit_ack,
    output logic                  exit_err,
    output logic [NUM_SPACES-1:0] occupancy,
    output logic [COUNT_W-1:0]    free_count,
    output logic                  full,
    output logic                  empty,
    output logic                  gate_open,
    output logic                  busy
);

    localparam logic [7:0] TIMER_LOAD = 8'(GATE_CYCLES - 1);

    state_t                  state_q;
    logic [NUM_SPACES-1:0]   occ_q;
    logic [NUM_SPACES-1:0]   occ_d;
    logic [7:0]              timer_q;
    logic [SPACE_W-1:0]      exit_idx_q;
    logic                    entry_ack_q;
    logic [SPACE_W-1:0]      entry_num_q;
    logic                    exit_ack_q;
    logic                    exit_err_q;
    logic                    gate_q;

    logic [SPACE_W-1:0]      free_idx;
    logic                    none_free;
    logic [NUM_SPACES-1:0]   clear_n;
    logic [COUNT_W-1:0]      free_cnt;

    free_space_finder u_finder (
        .occupancy_i (occ_q),
        .idx_o       (free_idx),
        .none_free_o (none_free)
    );

    // The exit index is latched at grant time so the decoder never sees
    // exit_number once the requester may have released it.
    exit_parking_lot u_exit_dec (
        .exit_number_i (exit_idx_q),
        .clear_n_o     (clear_n)
    );

    // Next occupancy: set the granted space at the close of ENTRY_GRANT, clear
    // the vacated space at the close of a valid EXIT_GRANT.
    always_comb begin
        occ_d = occ_q;
        if (state_q == ENTRY_GRANT) begin
            occ_d = occ_q | (NUM_SPACES'(1) << entry_num_q);
        end else if (state_q == EXIT_GRANT && !exit_err_q) begin
            occ_d = occ_q & clear_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            timer_q     <= '0;
            exit_idx_q  <= '0;
            entry_ack_q <= 1'b0;
            entry_num_q <= '0;
            exit_ack_q  <= 1'b0;
            exit_err_q  <= 1'b0;
            gate_q      <= 1'b0;
        end else begin
            // Grant outputs are single-cycle pulses; default them low.
            entry_ack_q <= 1'b0;
            entry_num_q <= '0;
            exit_ack_q  <= 1'b0;
            exit_err_q  <= 1'b0;
            occ_q       <= occ_d;

            unique case (state_q)
                IDLE: begin
                    // Exit wins ties because it frees a space.
                    if (exit_req) begin
                        state_q    <= EXIT_GRANT;
                        exit_ack_q <= 1'b1;
                        exit_idx_q <= exit_number;
                        exit_err_q <= ~occ_q[exit_number];
                    end else if (entry_req && !none_free) begin
                        state_q     <= ENTRY_GRANT;
                        entry_ack_q <= 1'b1;
                        entry_num_q <= free_idx;
                    end
                end
                ENTRY_GRANT: begin
                    timer_q <= TIMER_LOAD;
                    gate_q  <= 1'b1;
                    state_q <= GATE_HOLD;
                end
                EXIT_GRANT: begin
                    if (exit_err_q) begin
                        state_q <= RELEASE;
                    end else begin
                        timer_q <= TIMER_LOAD;
                        gate_q  <= 1'b1;
                        state_q <= GATE_HOLD;
                    end
                end
                GATE_HOLD: begin
                    if (timer_q == '0) begin
                        gate_q  <= 1'b0;
                        state_q <= RELEASE;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                RELEASE: begin
                    // One dead cycle so a requester dropping req right after
                    // its ack cannot be granted twice.
                    state_q <= IDLE;
                end
                default: begin
                    gate_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            free_cnt = free_cnt + COUNT_W'(~occ_q[i]);
        end
    end

    assign entry_ack    = entry_ack_q;
    assign entry_number = entry_num_q;
    assign exit_ack     = exit_ack_q;
    assign exit_err     = exit_err_q;
    assign occupancy    = occ_q;
    assign free_count   = free_cnt;
    assign full         = (occ_q == '1);
    assign empty        = (occ_q == '0);
    assign gate_open    = gate_q;
    assign busy         = (state_q != IDLE);

endmodule : parking_lot_controller
